// File: rtl/hit_scoreboard_if.sv
// Bundle between the game logic and hit_scoreboard: enemy positions, laser state,
// explosion-done handshake and the hit/score results.
interface hit_scoreboard_if #(
  parameter int NUM_ENEMIES = 8,
  parameter int SCORE_W     = 16
);
  localparam int IDX_W = $clog2(NUM_ENEMIES);

  logic [10*NUM_ENEMIES-1:0] enemy_x_flat;
  logic [10*NUM_ENEMIES-1:0] enemy_y_flat;
  logic [NUM_ENEMIES-1:0]    enemy_alive;
  logic [9:0]                laser_x;
  logic [9:0]                laser_y;
  logic                      laser_active;
  logic [NUM_ENEMIES-1:0]    done;
  logic [NUM_ENEMIES-1:0]    enemy_hit;
  logic                      laser_hit;
  logic [IDX_W-1:0]          hit_index;
  logic [SCORE_W-1:0]        score;

  // Level-based bundle, no handshake: the master holds positions/flags steady as
  // levels; laser_hit is a single-cycle pulse and hit_index is meaningful while
  // it is high (it keeps its last value otherwise).
  modport master (
    output enemy_x_flat, enemy_y_flat, enemy_alive, laser_x, laser_y,
           laser_active, done,
    input  enemy_hit, laser_hit, hit_index, score
  );

  modport slave (
    input  enemy_x_flat, enemy_y_flat, enemy_alive, laser_x, laser_y,
           laser_active, done,
    output enemy_hit, laser_hit, hit_index, score
  );
endinterface

// File: rtl/hit_scoreboard.sv
// Laser-vs-enemy collision scoreboard: one registered candidate stage, then a
// per-shot FSM that flags at most one enemy. Optional score counter: HIT_SCORE_EN.
module hit_scoreboard #(
  parameter int NUM_ENEMIES  = 8,
  parameter int ENEMY_SIZE   = 30,
  parameter int LASER_X_SIZE = 20,
  parameter int LASER_Y_SIZE = 49,
  parameter int SCORE_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  hit_scoreboard_if.slave  sb,
  output logic [1:0]       state_o
);
  localparam int IDX_W = $clog2(NUM_ENEMIES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] SPENT = 2'd2;

  localparam logic [10:0] ES  = 11'(ENEMY_SIZE);
  localparam logic [10:0] LXS = 11'(LASER_X_SIZE);
  localparam logic [10:0] LYS = 11'(LASER_Y_SIZE);

  logic [NUM_ENEMIES-1:0] cand_d, cand_q;
  logic                   active_q;
  logic [1:0]             state_d, state_q;
  logic [NUM_ENEMIES-1:0] enemy_hit_d, enemy_hit_q;
  logic                   laser_hit_d, laser_hit_q;
  logic [IDX_W-1:0]       hit_index_d, hit_index_q;

  logic [10:0]      ex_c, ey_c, lx_c, ly_c;
  logic             any_cand;
  logic [IDX_W-1:0] pick_idx;
  logic             evaluate;
  logic             fire;

  // Stage 1: 11-bit compares so edge-of-screen sums never wrap.
  always_comb begin
    cand_d = '0;
    ex_c   = '0;
    ey_c   = '0;
    lx_c   = {1'b0, sb.laser_x};
    ly_c   = {1'b0, sb.laser_y};
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      ex_c = {1'b0, sb.enemy_x_flat[10*i +: 10]};
      ey_c = {1'b0, sb.enemy_y_flat[10*i +: 10]};
      cand_d[i] = (lx_c <= ex_c + ES) && (lx_c + LXS >= ex_c) &&
                  (ly_c <= ey_c + ES) && (ly_c + LYS >= ey_c) &&
                  sb.enemy_alive[i] && !enemy_hit_q[i] && !sb.done[i];
    end
  end

  // Lowest-index candidate wins.
  always_comb begin
    any_cand = |cand_q;
    pick_idx = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (cand_q[i]) pick_idx = IDX_W'(i);
    end
  end

  // IDLE with a registered active laser is already a live shot, so the hit can be
  // taken on the same edge that would arm it; this keeps the latency at 2 cycles.
  // A done arriving with the hit cancels it and the shot stays armed.
  assign evaluate = (state_q == ARMED) || ((state_q == IDLE) && active_q);
  assign fire     = evaluate && any_cand && !sb.done[pick_idx];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (active_q) state_d = fire ? SPENT : ARMED;
      ARMED: begin
        if (fire)                       state_d = SPENT;
        else if (!any_cand && !active_q) state_d = IDLE;
      end
      SPENT:   if (!active_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enemy_hit_d = enemy_hit_q & ~sb.done;
    if (fire) enemy_hit_d[pick_idx] = 1'b1;
    laser_hit_d = fire;
    hit_index_d = fire ? pick_idx : hit_index_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cand_q      <= '0;
      active_q    <= 1'b0;
      state_q     <= IDLE;
      enemy_hit_q <= '0;
      laser_hit_q <= 1'b0;
      hit_index_q <= '0;
    end else begin
      cand_q      <= cand_d;
      active_q    <= sb.laser_active;
      state_q     <= state_d;
      enemy_hit_q <= enemy_hit_d;
      laser_hit_q <= laser_hit_d;
      hit_index_q <= hit_index_d;
    end
  end

`ifdef HIT_SCORE_EN
  logic [SCORE_W-1:0] score_d, score_q;

  always_comb begin
    score_d = score_q;
    if (fire && (score_q != {SCORE_W{1'b1}})) score_d = score_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) score_q <= '0;
    else       score_q <= score_d;
  end

  assign sb.score = score_q;
`else
  assign sb.score = {SCORE_W{1'b0}};
`endif

  assign sb.enemy_hit = enemy_hit_q;
  assign sb.laser_hit = laser_hit_q;
  assign sb.hit_index = hit_index_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_hit_scoreboard.sv
// Directed bench for hit_scoreboard: reset, overlap boundaries, priority,
// single-pulse-per-shot, done handling, mid-shot reset and score saturation.
module tb_hit_scoreboard;
  localparam int N  = 8;
  localparam int SW = 4;

  logic       clk;
  logic       rst;
  logic [1:0] state;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int exp_hits = 0;
  logic [31:0] exp_q[$];

  hit_scoreboard_if #(.NUM_ENEMIES(N), .SCORE_W(SW)) bus ();

  hit_scoreboard #(
    .NUM_ENEMIES(N), .ENEMY_SIZE(30), .LASER_X_SIZE(20),
    .LASER_Y_SIZE(49), .SCORE_W(SW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sb      (bus),
    .state_o (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_score();
`ifdef HIT_SCORE_EN
    return (exp_hits > 15) ? 32'd15 : 32'(exp_hits);
`else
    return 32'd0;
`endif
  endfunction

  // driver tasks
  task automatic set_enemy(input int i, input int x, input int y);
    bus.enemy_x_flat[10*i +: 10] = 10'(x);
    bus.enemy_y_flat[10*i +: 10] = 10'(y);
  endtask

  task automatic clear_hits();
    bus.done = '1;
    step(1);
    bus.done = '0;
    check("clear_hits", 32'(bus.enemy_hit), 32'd0);
  endtask

  // One shot: no pulse after one edge, result after two, then the shot is dropped.
  task automatic shot(input string tag, input int lx, input int ly,
                      input bit exp_hit, input int idx);
    logic [31:0] exp_idx;
    bus.laser_x      = 10'(lx);
    bus.laser_y      = 10'(ly);
    bus.laser_active = 1'b1;
    if (exp_hit) exp_q.push_back(32'(idx));
    step(1);
    check({tag, "_lat1"}, 32'(bus.laser_hit), 32'd0);
    step(1);
    check({tag, "_hit"}, 32'(bus.laser_hit), 32'(exp_hit));
    if (exp_hit) begin
      exp_idx = exp_q.pop_front();
      exp_hits++;
      check({tag, "_idx"}, 32'(bus.hit_index), exp_idx);
      check({tag, "_flag"}, 32'(bus.enemy_hit[idx]), 32'd1);
      check({tag, "_score"}, 32'(bus.score), exp_score());
    end
    bus.laser_active = 1'b0;
    step(3);
    check({tag, "_idle"}, 32'(state), 32'd0);
  endtask

  int pulses;
  int last_idx;

  initial begin
    rst = 1'b1;
    bus.enemy_x_flat = '0;
    bus.enemy_y_flat = '0;
    for (int i = 0; i < N; i++) set_enemy(i, 900, 900);
    bus.enemy_alive  = '0;
    bus.laser_x      = '0;
    bus.laser_y      = '0;
    bus.laser_active = 1'b0;
    bus.done         = '0;
    step(3);
    check("rst_enemy_hit", 32'(bus.enemy_hit), 32'd0);
    check("rst_laser_hit", 32'(bus.laser_hit), 32'd0);
    check("rst_hit_index", 32'(bus.hit_index), 32'd0);
    check("rst_score",     32'(bus.score),     32'd0);
    check("rst_state",     32'(state),         32'd0);
    rst = 1'b0;
    step(2);

    // Basic hit on enemy 0
    set_enemy(0, 110, 220);
    bus.enemy_alive = 8'h01;
    shot("basic", 100, 200, 1'b1, 0);
    check("basic_vec", 32'(bus.enemy_hit), 32'h01);
    clear_hits();

    // Laser fully covering enemy 3
    set_enemy(3, 5, 10);
    bus.enemy_alive = 8'h08;
    shot("contain", 0, 0, 1'b1, 3);
    check("contain_vec", 32'(bus.enemy_hit), 32'h08);
    clear_hits();

    // Inclusive bounds against enemy 4 at (100,100)
    set_enemy(4, 100, 100);
    bus.enemy_alive = 8'h10;
    shot("far",    500, 400, 1'b0, 4);
    shot("xmax",   130, 100, 1'b1, 4); clear_hits();
    shot("xmax1",  131, 100, 1'b0, 4);
    shot("xmin",    80, 100, 1'b1, 4); clear_hits();
    shot("xmin1",   79, 100, 1'b0, 4);
    shot("ymax",   100, 130, 1'b1, 4); clear_hits();
    shot("ymax1",  100, 131, 1'b0, 4);
    shot("ymin",   100,  51, 1'b1, 4); clear_hits();
    shot("ymin1",  100,  50, 1'b0, 4);
    bus.enemy_alive = 8'h00;
    shot("dead",   100, 100, 1'b0, 4);
    check("dead_vec", 32'(bus.enemy_hit), 32'd0);

    // Two overlapping enemies, laser held 10 cycles
    set_enemy(2, 50, 50);
    set_enemy(5, 60, 60);
    bus.enemy_alive  = 8'h24;
    bus.laser_x      = 10'd40;
    bus.laser_y      = 10'd40;
    bus.laser_active = 1'b1;
    pulses   = 0;
    last_idx = -1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (bus.laser_hit) begin
        pulses++;
        last_idx = int'(bus.hit_index);
      end
    end
    exp_hits++;
    check("prio_pulses", 32'(pulses), 32'd1);
    check("prio_idx",    32'(last_idx), 32'd2);
    check("prio_vec",    32'(bus.enemy_hit), 32'h04);
    check("prio_score",  32'(bus.score), exp_score());
    bus.laser_active = 1'b0;
    step(3);
    clear_hits();

    // Sticky flag cleared by done
    set_enemy(1, 200, 200);
    bus.enemy_alive = 8'h02;
    shot("sticky", 195, 195, 1'b1, 1);
    step(4);
    check("sticky_hold", 32'(bus.enemy_hit), 32'h02);
    bus.done = 8'h02;
    step(1);
    bus.done = '0;
    check("sticky_clr", 32'(bus.enemy_hit), 32'h00);

    // done coincident with a new hit on enemy 1
    bus.laser_x      = 10'd195;
    bus.laser_y      = 10'd195;
    bus.laser_active = 1'b1;
    step(1);
    bus.done         = 8'h02;
    bus.laser_active = 1'b0;
    step(1);
    check("coinc_pulse", 32'(bus.laser_hit), 32'd0);
    check("coinc_vec",   32'(bus.enemy_hit), 32'd0);
    check("coinc_armed", 32'(state), 32'd1);
    bus.done    = '0;
    bus.laser_x = 10'd600;
    step(3);
    check("coinc_idle",  32'(state), 32'd0);
    check("coinc_vec2",  32'(bus.enemy_hit), 32'd0);

    // Reset in SPENT with laser still active
    set_enemy(6, 300, 300);
    bus.enemy_alive  = 8'h40;
    bus.laser_x      = 10'd290;
    bus.laser_y      = 10'd290;
    bus.laser_active = 1'b1;
    step(2);
    check("mid_hit", 32'(bus.laser_hit), 32'd1);
    exp_hits++;
    step(1);
    check("mid_spent", 32'(state), 32'd2);
    rst = 1'b1;
    step(1);
    exp_hits = 0;
    check("mid_rst_vec",   32'(bus.enemy_hit), 32'd0);
    check("mid_rst_pulse", 32'(bus.laser_hit), 32'd0);
    check("mid_rst_idx",   32'(bus.hit_index), 32'd0);
    check("mid_rst_score", 32'(bus.score),     32'd0);
    check("mid_rst_state", 32'(state),         32'd0);
    rst = 1'b0;
    step(1);
    check("mid_lat1", 32'(bus.laser_hit), 32'd0);
    step(1);
    check("mid_rehit", 32'(bus.laser_hit), 32'd1);
    check("mid_reidx", 32'(bus.hit_index), 32'd6);
    check("mid_revec", 32'(bus.enemy_hit), 32'h40);
    exp_hits++;
    check("mid_score", 32'(bus.score), exp_score());
    bus.laser_active = 1'b0;
    step(3);
    clear_hits();

    // Score up to 17 hits
    bus.enemy_alive = 8'h01;
    while (exp_hits < 17) begin
      shot("score", 100, 200, 1'b1, 0);
      clear_hits();
    end
    check("score_final", 32'(bus.score), exp_score());
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/hit_scoreboard.md
HIT_SCOREBOARD -- requirements
Module: hit_scoreboard

Interface
REQ-001 Parameter NUM_ENEMIES, default 8, number of enemy ship channels (2..32).
REQ-002 Parameter ENEMY_SIZE, default 30, enemy ship square side in pixels.
REQ-003 Parameter LASER_X_SIZE, default 20, laser width in pixels.
REQ-004 Parameter LASER_Y_SIZE, default 49, laser height in pixels.
REQ-005 Parameter SCORE_W, default 16, score counter width.
REQ-006 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 enemy_x_flat  input  10*NUM_ENEMIES  enemy i X position in bits [10i+9:10i].
REQ-009 enemy_y_flat  input  10*NUM_ENEMIES  enemy i Y position, same packing.
REQ-010 enemy_alive  input  NUM_ENEMIES  enemy i is on screen and hittable.
REQ-011 laser_x, laser_y  input  10 each  user laser top-left position.
REQ-012 laser_active  input  1  a user laser shot is in flight.
REQ-013 done  input  NUM_ENEMIES  enemy i explosion finished; clears its hit flag.
REQ-014 enemy_hit  output  NUM_ENEMIES  sticky per-enemy hit flag.
REQ-015 laser_hit  output  1  one-cycle pulse: current shot struck an enemy.
REQ-016 hit_index  output  $clog2(NUM_ENEMIES)  index of enemy struck, valid with laser_hit.
REQ-017 score  output  SCORE_W  hit count (present only per REQ-034).

Function
REQ-018 Overlap of enemy i SHALL be: laser_x <= ex+ENEMY_SIZE and laser_x+LASER_X_SIZE >= ex and laser_y <= ey+ENEMY_SIZE and laser_y+LASER_Y_SIZE >= ey, all sums in 11 bits (no wrap), bounds inclusive.
REQ-019 Candidate i SHALL be overlap(i) AND enemy_alive[i] AND NOT enemy_hit[i] AND NOT done[i].
REQ-020 Stage 1: candidate vector and laser_active SHALL be registered (1 cycle after input sample).
REQ-021 Stage 2: FSM acts on registered candidates; hit outputs appear 2 cycles after inputs sampled.
REQ-022 FSM states IDLE, ARMED, SPENT.
REQ-023 IDLE -> ARMED when registered laser_active = 1.
REQ-024 ARMED with any registered candidate -> SPENT; same edge sets enemy_hit[k], pulses laser_hit, drives hit_index = k.
REQ-025 ARMED with registered laser_active = 0 and no candidate -> IDLE.
REQ-026 SPENT -> IDLE when registered laser_active = 0; no further hits SHALL be reported for that shot.
REQ-027 Multiple candidates: k SHALL be lowest index; exactly one enemy flagged per shot.
REQ-028 enemy_hit[i] SHALL stay set until done[i]=1, then clear on next edge.
REQ-029 done[i] and a new hit on i at same edge: clear wins, no laser_hit, FSM stays ARMED.
REQ-030 laser_hit SHALL be high exactly one cycle per hit; hit_index SHALL hold last value otherwise.

Reset
REQ-031 Reset SHALL set enemy_hit = 0, laser_hit = 0, hit_index = 0, score = 0, pipeline registers = 0, FSM = IDLE.
REQ-032 Reset asserted mid-shot SHALL abandon the shot; a laser still active after release SHALL be treated as a new shot (IDLE -> ARMED).
REQ-033 Reset SHALL take priority over done and all hit events.

Configuration
REQ-034 Macro HIT_SCORE_EN: defined -> score increments by 1 on each laser_hit, saturating at all-ones; undefined -> score port SHALL tie to 0 and no counter logic SHALL be built.

Verification
REQ-035 Laser (100,200), enemy0 (110,220), alive, active -> laser_hit pulse 2 cycles later, hit_index=0, enemy_hit=0x01.
REQ-036 Laser (0,0) fully containing enemy3 at (5,10), alive -> hit detected, hit_index=3; laser (500,400) vs enemy at (100,100) -> no hit.
REQ-037 Enemies 2 and 5 both overlap -> only enemy_hit[2] set, hit_index=2; laser held active 10 cycles -> single laser_hit pulse.
REQ-038 enemy_hit[1] set, done[1]=1 one cycle -> enemy_hit[1]=0 next edge; done coincident with new hit on 1 -> no pulse.
REQ-039 Reset asserted in SPENT with laser active -> all outputs 0; after release, laser still overlapping -> new hit reported.
REQ-040 HIT_SCORE_EN, SCORE_W=4, 17 hits -> score=15; without macro -> score=0 throughout.
